// File: rtl/bira_spare_alloc.sv
// bira_spare_alloc
// Online redundancy analysis behind the MBIST read pass. Fault words are
// registered (stage 1), then classified against the current spares and the
// pending single-fault buffer (stage 2). Spare rows and spare columns are
// allocated per bank. After test_end the block keeps accepting faults for
// FLUSH cycles. It then drains the pending buffer and holds the final
// solution together with a repairable verdict.
//
// Handshake: fault_detect is a valid-only strobe with no ready. Every
// qualified word seen on a clock edge while the FSM is in COLLECT or FLUSH is
// taken. A fault_bank code other than 2'b01/2'b10, or an all-zero
// fault_col_flag, is dropped silently.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   test              session enable (0->1 starts, 0 aborts or leaves DONE)
//   test_end          MBIST read pass finished
//   fault_detect      fault word valid
//   fault_bank        2'b01 bank 0, 2'b10 bank 1
//   fault_row         faulty row
//   fault_col         word base column
//   fault_col_flag    failing bits; bit k -> column fault_col + (7 - k)
//   busy              COLLECT / FLUSH / DRAIN
//   repair_done       solution valid (DONE)
//   repairable        all faults covered; meaningful with repair_done
//   spare_row_addr/vld  bank b slot s at index b*NSR+s (10-bit address each)
//   spare_col_addr/vld  bank b slot s at index b*NSC+s
//   dbg_state         current FSM state (0 IDLE,1 COLLECT,2 FLUSH,3 DRAIN,4 DONE)
module bira_spare_alloc #(
    parameter int NSR   = 2,
    parameter int NSC   = 2,
    parameter int PEND  = 4,
    parameter int FLUSH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  test,
    input  logic                  test_end,
    input  logic                  fault_detect,
    input  logic [1:0]            fault_bank,
    input  logic [9:0]            fault_row,
    input  logic [9:0]            fault_col,
    input  logic [7:0]            fault_col_flag,
    output logic                  busy,
    output logic                  repair_done,
    output logic                  repairable,
    output logic [2*NSR*10-1:0]   spare_row_addr,
    output logic [2*NSR-1:0]      spare_row_vld,
    output logic [2*NSC*10-1:0]   spare_col_addr,
    output logic [2*NSC-1:0]      spare_col_vld,
    output logic [2:0]            dbg_state
);
    localparam int CMAX = (FLUSH > 2*PEND) ? FLUSH : 2*PEND;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_FLUSH   = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // Stage 1 register
    logic            r_vld;
    logic            r_bank;
    logic [9:0]      r_row, r_col;
    logic [7:0]      r_flag;

    // Repair state and its next value
    logic [9:0]      row_a [2*NSR];
    logic [9:0]      col_a [2*NSC];
    logic [2*NSR-1:0] row_v;
    logic [2*NSC-1:0] col_v;
    logic [9:0]      p_row [2*PEND];
    logic [9:0]      p_col [2*PEND];
    logic [2*PEND-1:0] p_v;
    logic            rep;

    logic [9:0]      n_row_a [2*NSR];
    logic [9:0]      n_col_a [2*NSC];
    logic [2*NSR-1:0] n_row_v;
    logic [2*NSC-1:0] n_col_v;
    logic [9:0]      n_p_row [2*PEND];
    logic [9:0]      n_p_col [2*PEND];
    logic [2*PEND-1:0] n_p_v;
    logic            n_rep;

    // Stage 2 working set: the selected bank is copied out, edited, written back
    logic            session_start, go_word, go_drain, bk;
    logic [CW-1:0]   d_e, d_s;
    logic [9:0]      br_a [NSR];
    logic [9:0]      bc_a [NSC];
    logic [NSR-1:0]  br_v;
    logic [NSC-1:0]  bc_v;
    logic [9:0]      bp_row [PEND];
    logic [9:0]      bp_col [PEND];
    logic [PEND-1:0] bp_v;
    logic [9:0]      pc [8];
    logic            row_cov, col_hit, de_v, de_cov, placed, hit, unrep, ins, ac_x;
    logic [7:0]      u, ac_mask;
    logic [9:0]      ucol, m_prow, m_pcol, de_row, de_col, ar0, ar1, ac_xa, alloc_a;
    logic [PEND-1:0] m_row, m_col, f_mask, inv_mask;
    int              n_u, fr_rows, fr_cols, ar_n;

    always_comb begin
        n_row_a = row_a;  n_row_v = row_v;
        n_col_a = col_a;  n_col_v = col_v;
        n_p_row = p_row;  n_p_col = p_col;  n_p_v = p_v;
        n_rep   = rep;

        session_start = (state == S_IDLE) && test;
        go_word  = r_vld && rep && (state == S_COLLECT || state == S_FLUSH || state == S_DRAIN);
        // DRAIN cycle 0 is left for the last word still in stage 1; cycles 1..2*PEND scan entries.
        go_drain = rep && (state == S_DRAIN) && (cnt != '0);
        d_e      = cnt - CW'(1);
        bk       = go_drain ? (d_e >= CW'(PEND)) : r_bank;
        d_s      = d_e - (bk ? CW'(PEND) : CW'(0));

        for (int s = 0; s < NSR; s++) begin
            br_a[s] = bk ? row_a[NSR+s] : row_a[s];
            br_v[s] = bk ? row_v[NSR+s] : row_v[s];
        end
        for (int s = 0; s < NSC; s++) begin
            bc_a[s] = bk ? col_a[NSC+s] : col_a[s];
            bc_v[s] = bk ? col_v[NSC+s] : col_v[s];
        end
        for (int p = 0; p < PEND; p++) begin
            bp_row[p] = bk ? p_row[PEND+p] : p_row[p];
            bp_col[p] = bk ? p_col[PEND+p] : p_col[p];
            bp_v[p]   = bk ? p_v[PEND+p]   : p_v[p];
        end

        // Uncovered bits of the stage-2 word
        for (int k = 0; k < 8; k++) pc[k] = r_col + 10'(7 - k);
        row_cov = 1'b0;
        for (int s = 0; s < NSR; s++)
            if (br_v[s] && br_a[s] == r_row) row_cov = 1'b1;
        u = '0;
        col_hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
            col_hit = 1'b0;
            for (int s = 0; s < NSC; s++)
                if (bc_v[s] && bc_a[s] == pc[k]) col_hit = 1'b1;
            u[k] = r_flag[k] && !row_cov && !col_hit;
        end
        n_u = 0;
        ucol = '0;
        for (int k = 0; k < 8; k++)
            if (u[k]) begin
                n_u  = n_u + 1;
                ucol = pc[k];
            end
        fr_rows = 0;
        fr_cols = 0;
        for (int s = 0; s < NSR; s++) if (!br_v[s]) fr_rows = fr_rows + 1;
        for (int s = 0; s < NSC; s++) if (!bc_v[s]) fr_cols = fr_cols + 1;

        // Pending buffer lookups (lowest index wins)
        m_row = '0;  m_col = '0;  f_mask = '0;
        m_prow = '0; m_pcol = '0;
        for (int p = 0; p < PEND; p++)
            if (!(|m_row) && bp_v[p] && bp_row[p] == r_row) begin
                m_row[p] = 1'b1;
                m_pcol   = bp_col[p];
            end
        for (int p = 0; p < PEND; p++)
            if (!(|m_col) && bp_v[p] && bp_col[p] == ucol) begin
                m_col[p] = 1'b1;
                m_prow   = bp_row[p];
            end
        for (int p = 0; p < PEND; p++)
            if (!(|f_mask) && !bp_v[p]) f_mask[p] = 1'b1;

        // Entry under the drain pointer
        de_v = 1'b0;  de_row = '0;  de_col = '0;
        for (int p = 0; p < PEND; p++)
            if (d_s == CW'(p)) begin
                de_v   = bp_v[p];
                de_row = bp_row[p];
                de_col = bp_col[p];
            end
        de_cov = 1'b0;
        for (int s = 0; s < NSR; s++) if (br_v[s] && br_a[s] == de_row) de_cov = 1'b1;
        for (int s = 0; s < NSC; s++) if (bc_v[s] && bc_a[s] == de_col) de_cov = 1'b1;

        // Decision
        ar_n = 0;  ar0 = '0;  ar1 = '0;
        ac_mask = '0;  ac_x = 1'b0;  ac_xa = '0;
        unrep = 1'b0;  ins = 1'b0;  inv_mask = '0;
        if (go_word) begin
            if (n_u >= 2) begin
                if (fr_rows >= 1) begin ar_n = 1; ar0 = r_row; end
                else if (fr_cols >= n_u) ac_mask = u;
                else unrep = 1'b1;
            end else if (n_u == 1) begin
                if (|m_row) begin
                    inv_mask = m_row;
                    if (fr_rows >= 1) begin ar_n = 1; ar0 = r_row; end
                    else if (fr_cols >= 2) begin ac_mask = u; ac_x = 1'b1; ac_xa = m_pcol; end
                    else unrep = 1'b1;
                end else if (|m_col) begin
                    inv_mask = m_col;
                    if (fr_cols >= 1) ac_mask = u;
                    else if (fr_rows >= 2) begin ar_n = 2; ar0 = r_row; ar1 = m_prow; end
                    else unrep = 1'b1;
                end else if (|f_mask) ins = 1'b1;
                else if (fr_rows >= 1) begin ar_n = 1; ar0 = r_row; end
                else if (fr_cols >= 1) ac_mask = u;
                else unrep = 1'b1;
            end
        end else if (go_drain && de_v && !de_cov) begin
            for (int p = 0; p < PEND; p++) if (d_s == CW'(p)) inv_mask[p] = 1'b1;
            if (fr_rows >= 1) begin ar_n = 1; ar0 = de_row; end
            else if (fr_cols >= 1) begin ac_x = 1'b1; ac_xa = de_col; end
            else unrep = 1'b1;
        end

        // Apply to the bank copy; spares take the lowest free slot
        bp_v = bp_v & ~inv_mask;
        for (int p = 0; p < PEND; p++)
            if (ins && f_mask[p]) begin
                bp_v[p]   = 1'b1;
                bp_row[p] = r_row;
                bp_col[p] = ucol;
            end
        placed = 1'b0;
        alloc_a = '0;
        for (int i = 0; i < 2; i++)
            if (i < ar_n) begin
                alloc_a = (i == 0) ? ar0 : ar1;
                placed  = 1'b0;
                for (int s = 0; s < NSR; s++)
                    if (!placed && !br_v[s]) begin
                        br_v[s] = 1'b1;
                        br_a[s] = alloc_a;
                        placed  = 1'b1;
                    end
            end
        for (int k = 0; k < 9; k++)
            if ((k < 8) ? ac_mask[k[2:0]] : ac_x) begin
                alloc_a = (k < 8) ? pc[k[2:0]] : ac_xa;
                placed  = 1'b0;
                for (int s = 0; s < NSC; s++)
                    if (!placed && !bc_v[s]) begin
                        bc_v[s] = 1'b1;
                        bc_a[s] = alloc_a;
                        placed  = 1'b1;
                    end
            end
        // Any new spare may also cover faults parked in the buffer
        hit = 1'b0;
        if (ar_n > 0 || (|ac_mask) || ac_x)
            for (int p = 0; p < PEND; p++) begin
                hit = 1'b0;
                for (int s = 0; s < NSR; s++) if (br_v[s] && br_a[s] == bp_row[p]) hit = 1'b1;
                for (int s = 0; s < NSC; s++) if (bc_v[s] && bc_a[s] == bp_col[p]) hit = 1'b1;
                if (hit) bp_v[p] = 1'b0;
            end
        if (unrep) n_rep = 1'b0;

        for (int s = 0; s < NSR; s++)
            if (bk) begin n_row_a[NSR+s] = br_a[s]; n_row_v[NSR+s] = br_v[s]; end
            else    begin n_row_a[s]     = br_a[s]; n_row_v[s]     = br_v[s]; end
        for (int s = 0; s < NSC; s++)
            if (bk) begin n_col_a[NSC+s] = bc_a[s]; n_col_v[NSC+s] = bc_v[s]; end
            else    begin n_col_a[s]     = bc_a[s]; n_col_v[s]     = bc_v[s]; end
        for (int p = 0; p < PEND; p++)
            if (bk) begin
                n_p_row[PEND+p] = bp_row[p]; n_p_col[PEND+p] = bp_col[p]; n_p_v[PEND+p] = bp_v[p];
            end else begin
                n_p_row[p] = bp_row[p]; n_p_col[p] = bp_col[p]; n_p_v[p] = bp_v[p];
            end

        if (session_start) begin
            n_row_v = '0;  n_col_v = '0;  n_p_v = '0;  n_rep = 1'b1;
            for (int i = 0; i < 2*NSR; i++)  n_row_a[i] = '0;
            for (int i = 0; i < 2*NSC; i++)  n_col_a[i] = '0;
            for (int i = 0; i < 2*PEND; i++) begin n_p_row[i] = '0; n_p_col[i] = '0; end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;  cnt <= '0;
            busy <= 1'b0;  repair_done <= 1'b0;  rep <= 1'b0;
            r_vld <= 1'b0;  r_bank <= 1'b0;  r_row <= '0;  r_col <= '0;  r_flag <= '0;
            row_v <= '0;  col_v <= '0;  p_v <= '0;
            for (int i = 0; i < 2*NSR; i++)  row_a[i] <= '0;
            for (int i = 0; i < 2*NSC; i++)  col_a[i] <= '0;
            for (int i = 0; i < 2*PEND; i++) begin p_row[i] <= '0; p_col[i] <= '0; end
        end else begin
            row_a <= n_row_a;  row_v <= n_row_v;
            col_a <= n_col_a;  col_v <= n_col_v;
            p_row <= n_p_row;  p_col <= n_p_col;  p_v <= n_p_v;
            rep   <= n_rep;

            r_vld <= 1'b0;
            if ((state == S_COLLECT || state == S_FLUSH) && fault_detect &&
                (fault_bank == 2'b01 || fault_bank == 2'b10) && fault_col_flag != '0) begin
                r_vld  <= 1'b1;
                r_bank <= fault_bank[1];
                r_row  <= fault_row;
                r_col  <= fault_col;
                r_flag <= fault_col_flag;
            end

            case (state)
                S_IDLE: if (test) begin
                    state <= S_COLLECT;  busy <= 1'b1;  cnt <= '0;  r_vld <= 1'b0;
                end
                S_COLLECT, S_FLUSH, S_DRAIN: begin
                    if (!test) begin
                        state <= S_IDLE;  busy <= 1'b0;  cnt <= '0;  r_vld <= 1'b0;
                    end else if (state == S_COLLECT) begin
                        if (test_end) begin state <= S_FLUSH; cnt <= '0; end
                    end else if (state == S_FLUSH) begin
                        if (cnt == CW'(FLUSH - 1)) begin state <= S_DRAIN; cnt <= '0; end
                        else cnt <= cnt + CW'(1);
                    end else begin
                        if (cnt == CW'(2*PEND)) begin
                            state <= S_DONE;  busy <= 1'b0;  repair_done <= 1'b1;  cnt <= '0;
                        end else cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: if (!test) begin state <= S_IDLE; repair_done <= 1'b0; end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 2*NSR; i++) begin : g_row_out
        assign spare_row_addr[i*10 +: 10] = row_a[i];
    end
    for (genvar i = 0; i < 2*NSC; i++) begin : g_col_out
        assign spare_col_addr[i*10 +: 10] = col_a[i];
    end
    assign spare_row_vld = row_v;
    assign spare_col_vld = col_v;
    assign repairable    = rep;
    assign dbg_state     = state;

endmodule
